// File: rtl/pe_neuron_loader_pkg.sv
// Shared types and helpers for the PE neuron loader: FSM encoding and lane-index sizing.
package pe_neuron_loader_pkg;

    localparam int unsigned DEF_NUM_PE            = 4;
    localparam int unsigned DEF_PE_BUF_ADDR_WIDTH = 10;
    localparam int unsigned DEF_OP_WIDTH          = 16;
    localparam int unsigned DEF_COUNT_WIDTH       = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PAD  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Lane index needs at least one bit even for a single-lane build.
    function automatic int unsigned lane_width(input int unsigned num_pe);
        return (num_pe <= 1) ? 1 : $clog2(num_pe);
    endfunction

endpackage

// File: rtl/pe_lane_addr_counter.sv
// Lane/round counter: walks lanes 0..NUM_PE-1 and bumps the buffer address on each wrap.
module pe_lane_addr_counter
    import pe_neuron_loader_pkg::*;
#(
    parameter int unsigned NUM_PE     = DEF_NUM_PE,
    parameter int unsigned ADDR_WIDTH = DEF_PE_BUF_ADDR_WIDTH,
    parameter int unsigned LANE_WIDTH = lane_width(NUM_PE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  advance,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic [LANE_WIDTH-1:0] lane,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  wrap_c
);

    localparam logic [LANE_WIDTH-1:0] LAST_LANE = LANE_WIDTH'(NUM_PE - 1);

    assign wrap_c = (lane == LAST_LANE);

    // addr carries base+round directly; overflow past the buffer top wraps silently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane <= '0;
            addr <= '0;
        end else if (clear) begin
            lane <= '0;
            addr <= base_addr;
        end else if (advance) begin
            if (wrap_c) begin
                lane <= '0;
                addr <= addr + ADDR_WIDTH'(1);
            end else begin
                lane <= lane + LANE_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/pe_neuron_loader.sv
// Scatters a valid/ready word stream round-robin into NUM_PE neuron buffers.
// Optional zero padding of unfilled lanes in the last round: define PE_LOADER_ZERO_PAD_EN.
module pe_neuron_loader
    import pe_neuron_loader_pkg::*;
#(
    parameter int unsigned NUM_PE            = DEF_NUM_PE,
    parameter int unsigned PE_BUF_ADDR_WIDTH = DEF_PE_BUF_ADDR_WIDTH,
    parameter int unsigned OP_WIDTH          = DEF_OP_WIDTH,
    parameter int unsigned COUNT_WIDTH       = DEF_COUNT_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_start,
    input  logic [PE_BUF_ADDR_WIDTH-1:0] cmd_base_addr,
    input  logic [COUNT_WIDTH-1:0]       cmd_num_words,
    input  logic                         hold,
    input  logic [OP_WIDTH-1:0]          in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [NUM_PE-1:0]            pe_neuron_write_req,
    output logic [PE_BUF_ADDR_WIDTH-1:0] pe_neuron_write_addr,
    output logic [OP_WIDTH-1:0]          pe_neuron_write_data,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned LANE_WIDTH = lane_width(NUM_PE);

    state_e                         state_q;
    state_e                         state_d;
    logic [COUNT_WIDTH-1:0]         num_q;
    logic [COUNT_WIDTH-1:0]         count_q;
    logic [COUNT_WIDTH-1:0]         remaining_c;
    logic [LANE_WIDTH-1:0]          lane;
    logic [PE_BUF_ADDR_WIDTH-1:0]   lane_addr;
    logic                           wrap_c;
    logic                           start_c;
    logic                           accept_c;
    logic                           last_c;
    logic                           pad_fire_c;
    logic                           wr_fire_c;
    logic [OP_WIDTH-1:0]            wr_data_c;

    assign remaining_c = num_q - count_q;

    pe_lane_addr_counter #(
        .NUM_PE     (NUM_PE),
        .ADDR_WIDTH (PE_BUF_ADDR_WIDTH),
        .LANE_WIDTH (LANE_WIDTH)
    ) u_lane_addr (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_c),
        .advance   (wr_fire_c),
        .base_addr (cmd_base_addr),
        .lane      (lane),
        .addr      (lane_addr),
        .wrap_c    (wrap_c)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_start) begin
                    state_d = (cmd_num_words == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (last_c) begin
`ifdef PE_LOADER_ZERO_PAD_EN
                    // Pad only when the final word left lanes of its round unwritten.
                    state_d = wrap_c ? ST_DONE : ST_PAD;
`else
                    state_d = ST_DONE;
`endif
                end
            end
            ST_PAD: begin
                if (pad_fire_c && wrap_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake and write-strobe decode; in_ready never looks at in_valid.
    always_comb begin
        in_ready   = 1'b0;
        start_c    = 1'b0;
        pad_fire_c = 1'b0;
        case (state_q)
            ST_IDLE: start_c    = cmd_start;
            ST_LOAD: in_ready   = !hold && (remaining_c != '0);
            ST_PAD:  pad_fire_c = !hold;
            default: ;
        endcase
        accept_c  = in_valid && in_ready;
        last_c    = accept_c && (remaining_c == COUNT_WIDTH'(1));
        wr_fire_c = accept_c || pad_fire_c;
        wr_data_c = accept_c ? in_data : '0;
    end

    // Command latch, word counter and registered PE-side outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            num_q                <= '0;
            count_q              <= '0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            pe_neuron_write_req  <= '0;
            pe_neuron_write_addr <= '0;
            pe_neuron_write_data <= '0;
        end else begin
            if (start_c) begin
                num_q   <= cmd_num_words;
                count_q <= '0;
            end else if (accept_c) begin
                count_q <= count_q + COUNT_WIDTH'(1);
            end
            busy <= (state_d != ST_IDLE);
            done <= (state_d == ST_DONE);
            if (wr_fire_c) begin
                pe_neuron_write_req  <= NUM_PE'(1) << lane;
                pe_neuron_write_addr <= lane_addr;
                pe_neuron_write_data <= wr_data_c;
            end else begin
                pe_neuron_write_req  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pe_neuron_loader.sv
// Self-checking bench for pe_neuron_loader: queue-based write model plus literal spot checks.
module tb_pe_neuron_loader;

    localparam int unsigned NUM_PE = 4;
    localparam int unsigned AW     = 10;
    localparam int unsigned OW     = 16;
    localparam int unsigned CW     = 16;

    typedef struct packed {
        logic [NUM_PE-1:0] req;
        logic [AW-1:0]     addr;
        logic [OW-1:0]     data;
    } exp_t;

    typedef struct {
        logic [NUM_PE-1:0] req;
        logic [AW-1:0]     addr;
        logic [OW-1:0]     data;
        int                cyc;
    } wr_t;

    logic              clk;
    logic              reset;
    logic              cmd_start;
    logic [AW-1:0]     cmd_base_addr;
    logic [CW-1:0]     cmd_num_words;
    logic              hold;
    logic [OW-1:0]     in_data;
    logic              in_valid;
    logic              in_ready;
    logic [NUM_PE-1:0] wr_req;
    logic [AW-1:0]     wr_addr;
    logic [OW-1:0]     wr_data;
    logic              busy;
    logic              done;

    int checks   = 0;
    int failures = 0;

    // Model state
    exp_t     exp_q[$];
    wr_t      wr_log[$];
    bit       model_idle    = 1'b1;
    int       left          = 0;
    bit       exp_write_now = 1'b0;
    bit       exp_done_now  = 1'b0;
    logic [OW-1:0] tb_first = '0;
    int       cyc       = 0;
    int       start_cyc = 0;
    int       done_cyc  = 0;

    pe_neuron_loader #(
        .NUM_PE            (NUM_PE),
        .PE_BUF_ADDR_WIDTH (AW),
        .OP_WIDTH          (OW),
        .COUNT_WIDTH       (CW)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .cmd_start            (cmd_start),
        .cmd_base_addr        (cmd_base_addr),
        .cmd_num_words        (cmd_num_words),
        .hold                 (hold),
        .in_data              (in_data),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .pe_neuron_write_req  (wr_req),
        .pe_neuron_write_addr (wr_addr),
        .pe_neuron_write_data (wr_data),
        .busy                 (busy),
        .done                 (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected write list for one command, straight from the scatter rule.
    task automatic build_expect(input logic [AW-1:0] base, input logic [CW-1:0] num);
        exp_t ent;
        for (int i = 0; i < int'(num); i++) begin
            ent.req  = NUM_PE'(1 << (i % NUM_PE));
            ent.addr = AW'(int'(base) + i / NUM_PE);
            ent.data = OW'(int'(tb_first) + i);
            exp_q.push_back(ent);
        end
`ifdef PE_LOADER_ZERO_PAD_EN
        if (int'(num) % NUM_PE != 0) begin
            for (int l = int'(num) % NUM_PE; l < NUM_PE; l++) begin
                ent.req  = NUM_PE'(1 << l);
                ent.addr = AW'(int'(base) + (int'(num) - 1) / NUM_PE);
                ent.data = '0;
                exp_q.push_back(ent);
            end
        end
`endif
    endtask

    // Compare process: checks every output each cycle, then advances the model.
    exp_t e;
    bit   rdy_exp;
    bit   was_idle;
    always @(negedge clk) begin
        if (reset) begin
            cyc++;
            if (wr_req != '0) wr_log.push_back('{wr_req, wr_addr, wr_data, cyc});
            if (exp_write_now && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("write_req",  32'(wr_req),  32'(e.req));
                check("write_addr", 32'(wr_addr), 32'(e.addr));
                check("write_data", 32'(wr_data), 32'(e.data));
            end else begin
                check("no_write", 32'(wr_req), 32'd0);
            end
            check("done", 32'(done), 32'(exp_done_now));
            if (done) done_cyc = cyc;
            check("busy", 32'(busy), 32'(!model_idle));
            rdy_exp = !model_idle && (left > 0) && !hold;
            check("in_ready", 32'(in_ready), 32'(rdy_exp));

            was_idle = model_idle;
            if (exp_done_now) model_idle = 1'b1;
            exp_write_now = 1'b0;
            exp_done_now  = 1'b0;
            if (!model_idle) begin
                if (rdy_exp && in_valid) begin
                    left--;
                    exp_write_now = 1'b1;
                end else if (left == 0 && exp_q.size() > 0 && !hold) begin
                    exp_write_now = 1'b1;
                end
                exp_done_now = exp_write_now && (exp_q.size() == 1);
            end
            if (was_idle && cmd_start) begin
                model_idle = 1'b0;
                start_cyc  = cyc;
                left       = int'(cmd_num_words);
                build_expect(cmd_base_addr, cmd_num_words);
                if (cmd_num_words == '0) exp_done_now = 1'b1;
            end
        end
    end

    // Issue one command and stream words first, first+1, ... with optional hold window.
    task automatic load(input logic [AW-1:0] base, input logic [CW-1:0] num,
                        input logic [OW-1:0] first, input int hold_lo, input int hold_hi,
                        input int start2_at, input int stop_after);
        int acc;
        int lc;
        int g;
        tb_first      = first;
        cmd_base_addr = base;
        cmd_num_words = num;
        cmd_start     = 1'b1;
        wr_log.delete();
        step();
        cmd_start = 1'b0;
        acc = 0;
        lc  = 1;
        g   = 0;
        while (acc < stop_after && g < 200) begin
            in_valid = 1'b1;
            in_data  = first + OW'(acc);
            hold     = (lc >= hold_lo) && (lc <= hold_hi);
            if (lc == start2_at) begin
                cmd_start     = 1'b1;
                cmd_base_addr = 10'h155;
                cmd_num_words = 16'd3;
            end else begin
                cmd_start = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            step();
            lc++;
            g++;
        end
        if (acc < stop_after) check("accept_budget", 32'(acc), 32'(stop_after));
        in_valid  = 1'b0;
        hold      = 1'b0;
        cmd_start = 1'b0;
        if (stop_after == int'(num)) begin
            g = 0;
            while (!model_idle && g < 40) begin
                step();
                g++;
            end
            if (!model_idle) check("done_timeout", 32'(g), 32'd0);
            check("queue_drained", 32'(exp_q.size()), 32'd0);
            step();
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b0;
        cmd_start     = 1'b0;
        cmd_base_addr = '0;
        cmd_num_words = '0;
        hold          = 1'b0;
        in_data       = '0;
        in_valid      = 1'b0;
        repeat (2) step();
        check("rst_req",   32'(wr_req),   32'd0);
        check("rst_addr",  32'(wr_addr),  32'd0);
        check("rst_data",  32'(wr_data),  32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_busy",  32'(busy),     32'd0);
        check("rst_done",  32'(done),     32'd0);
        reset = 1'b1;
        step();
        step();

        // Reset in the middle of a load: outputs clear at once, nothing resumes.
        load(10'h020, 16'd8, 16'h00A0, 0, -1, 0, 3);
        in_valid = 1'b1;
        reset    = 1'b0;
        #1;
        check("midrst_req",   32'(wr_req),   32'd0);
        check("midrst_addr",  32'(wr_addr),  32'd0);
        check("midrst_data",  32'(wr_data),  32'd0);
        check("midrst_ready", 32'(in_ready), 32'd0);
        check("midrst_busy",  32'(busy),     32'd0);
        exp_q.delete();
        model_idle    = 1'b1;
        left          = 0;
        exp_write_now = 1'b0;
        exp_done_now  = 1'b0;
        step();
        step();
        reset   = 1'b1;
        in_data = 16'hDEAD;
        repeat (5) step();
        in_valid = 1'b0;
        check("midrst_log_size", 32'(wr_log.size()), 32'd2);
        check("midrst_log1", {wr_log[1].req, wr_log[1].addr, wr_log[1].data[11:0]},
              {4'b0010, 10'h020, 12'h0A1});

        // Basic back-to-back load of 8 words.
        load(10'h010, 16'd8, 16'd1, 0, -1, 0, 8);
        check("basic_count", 32'(wr_log.size()), 32'd8);
        check("basic_w0",  {wr_log[0].req, wr_log[0].addr, wr_log[0].data[11:0]}, {4'b0001, 10'h010, 12'd1});
        check("basic_w3",  {wr_log[3].req, wr_log[3].addr, wr_log[3].data[11:0]}, {4'b1000, 10'h010, 12'd4});
        check("basic_w4",  {wr_log[4].req, wr_log[4].addr, wr_log[4].data[11:0]}, {4'b0001, 10'h011, 12'd5});
        check("basic_w7",  {wr_log[7].req, wr_log[7].addr, wr_log[7].data[11:0]}, {4'b1000, 10'h011, 12'd8});
        check("basic_last_lat", 32'(wr_log[7].cyc - start_cyc), 32'd9);
        check("basic_done_lat", 32'(done_cyc - start_cyc), 32'd9);

        // Same command with hold during LOAD cycles 3-5.
        load(10'h010, 16'd8, 16'd1, 3, 5, 0, 8);
        check("hold_count", 32'(wr_log.size()), 32'd8);
        check("hold_w1_lat", 32'(wr_log[1].cyc - start_cyc), 32'd3);
        check("hold_w2_lat", 32'(wr_log[2].cyc - start_cyc), 32'd7);
        check("hold_done_lat", 32'(done_cyc - start_cyc), 32'd12);
        check("hold_w6", {wr_log[6].req, wr_log[6].addr, wr_log[6].data[11:0]}, {4'b0100, 10'h011, 12'd7});

        // Empty command: immediate done, no writes.
        load(10'h000, 16'd0, 16'd0, 0, -1, 0, 0);
        check("zero_count", 32'(wr_log.size()), 32'd0);
        check("zero_done_lat", 32'(done_cyc - start_cyc), 32'd1);

        // Address wrap past the buffer top plus an ignored restart mid-load.
        load(10'h3FF, 16'd8, 16'h0200, 0, -1, 4, 8);
        check("wrap_count", 32'(wr_log.size()), 32'd8);
        check("wrap_w0", {wr_log[0].req, wr_log[0].addr}, {4'b0001, 10'h3FF});
        check("wrap_w4", {wr_log[4].req, wr_log[4].addr}, {4'b0001, 10'h000});
        check("wrap_w7", {wr_log[7].req, wr_log[7].addr, wr_log[7].data[11:0]}, {4'b1000, 10'h000, 12'h207});

        // Partial last round.
        load(10'h040, 16'd6, 16'h0100, 0, -1, 0, 6);
        check("part_w5", {wr_log[5].req, wr_log[5].addr, wr_log[5].data[11:0]}, {4'b0010, 10'h041, 12'h105});
`ifdef PE_LOADER_ZERO_PAD_EN
        check("pad_count", 32'(wr_log.size()), 32'd8);
        check("pad_w6", {wr_log[6].req, wr_log[6].addr, wr_log[6].data[11:0]}, {4'b0100, 10'h041, 12'h000});
        check("pad_w7", {wr_log[7].req, wr_log[7].addr, wr_log[7].data[11:0]}, {4'b1000, 10'h041, 12'h000});
        check("pad_done_lat", 32'(done_cyc - start_cyc), 32'd9);
`else
        check("nopad_count", 32'(wr_log.size()), 32'd6);
        check("nopad_done_lat", 32'(done_cyc - start_cyc), 32'd7);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
